// File: rtl/series_pkg.sv
// -----------------------------------------------------------------------------
// series_pkg
// Shared types and constants for the series evaluator (series_ctrl).
//   state_e    : controller state encoding
//   X_W        : operand width (unsigned Q0.8)
//   TERM_W     : term / result width (unsigned Q1.15)
//   ACC_W      : accumulator width (signed, two guard bits above Q1.15)
//   ONE_Q15    : 1.0 in Q1.15
//   sat_result : clamp a signed accumulator value into the 16-bit result range
// -----------------------------------------------------------------------------
package series_pkg;

  localparam int X_W    = 8;
  localparam int TERM_W = 16;
  localparam int ACC_W  = 18;

  localparam logic [TERM_W-1:0] ONE_Q15 = 16'h8000;

  localparam logic signed [ACC_W-1:0] ACC_ONE = 18'sh08000;
  localparam logic signed [ACC_W-1:0] ACC_MAX = 18'sh1FFFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 18'sh20000;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    STEP_A,
    STEP_B,
    FINISH
  } state_e;

  // Negative clamps to 0, anything at or above 2.0 clamps to 0xFFFF.
  function automatic logic [TERM_W-1:0] sat_result(input logic signed [ACC_W-1:0] acc);
    logic [TERM_W-1:0] r;
    if (acc[ACC_W-1]) begin
      r = '0;
    end else if (acc[ACC_W-2:TERM_W] != '0) begin
      r = '1;
    end else begin
      r = acc[TERM_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/series_mul.sv
// -----------------------------------------------------------------------------
// series_mul
// Truncating unsigned 16x8 multiply, result = (a * b) >> 8, 16 bits.
//   a_i : 16-bit unsigned multiplicand
//   b_i : 8-bit unsigned multiplier (Q0.8)
//   p_o : bits [23:8] of the full product
// Purely combinational; shared by the squaring and both term-update steps.
// -----------------------------------------------------------------------------
module series_mul
  import series_pkg::*;
(
  input  logic [TERM_W-1:0] a_i,
  input  logic [X_W-1:0]    b_i,
  output logic [TERM_W-1:0] p_o
);

  logic [TERM_W+X_W-1:0] prod;

  assign prod = {{X_W{1'b0}}, a_i} * {{TERM_W{1'b0}}, b_i};
  assign p_o  = prod[TERM_W+X_W-1:X_W];

endmodule

// File: rtl/series_ctrl.sv
// -----------------------------------------------------------------------------
// series_ctrl
// Evaluates acc = 1 + sum(t_k), t_k = t_(k-1) * x^2 * c_k, over TERMS terms,
// with the coefficients c_k read from an external combinational ROM.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : evaluation request, sampled only in IDLE
//   x_in     : operand x, unsigned Q0.8, captured on accepted start
//   lut_adr  : coefficient ROM address (0 outside STEP_A/STEP_B)
//   lut_data : coefficient for lut_adr, unsigned Q0.8
//   busy     : high from the start-accept edge until done
//   done     : one-cycle result-valid pulse
//   result   : saturated sum, unsigned Q1.15, held until the next done
//
// Build option
//   SERIES_ALT_SIGN_EN : when defined, term k is subtracted for even k and
//                        added for odd k (1 - t1 + t2 - ...); otherwise every
//                        term is added.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; accepting captures x and seeds term/acc
// SQUARE | x2 = (x*x) >> 8
// STEP_A | lut_adr = k, p = (term*x2) >> 8
// STEP_B | lut_adr = k, term = (p*lut_data) >> 8, acc updated, k advances
// FINISH | result loaded (saturated), done pulses on the following cycle
// -----------------------------------------------------------------------------
module series_ctrl
  import series_pkg::*;
#(
  parameter int TERMS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  output logic [2:0]        lut_adr,
  input  logic [X_W-1:0]    lut_data,
  output logic              busy,
  output logic              done,
  output logic [TERM_W-1:0] result
);

  localparam logic [2:0] K_LAST = 3'(TERMS - 1);

  state_e                   state_q, state_d;
  logic [X_W-1:0]           x_q, x_d;
  logic [X_W-1:0]           x2_q, x2_d;
  logic [TERM_W-1:0]        term_q, term_d;
  logic [TERM_W-1:0]        p_q, p_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]               k_q, k_d;
  logic [TERM_W-1:0]        result_q, result_d;
  logic                     done_q, done_d;

  logic [TERM_W-1:0]        mul_a;
  logic [X_W-1:0]           mul_b;
  logic [TERM_W-1:0]        mul_p;

  logic                     acc_sub;
  logic [ACC_W:0]           acc_ext;
  logic [ACC_W:0]           term_ext;
  logic [ACC_W:0]           acc_sum;
  logic signed [ACC_W-1:0]  acc_next;

  // One multiplier, operands steered by state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      SQUARE: begin
        mul_a = {{(TERM_W-X_W){1'b0}}, x_q};
        mul_b = x_q;
      end
      STEP_A: begin
        mul_a = term_q;
        mul_b = x2_q;
      end
      STEP_B: begin
        mul_a = p_q;
        mul_b = lut_data;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  series_mul u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

`ifdef SERIES_ALT_SIGN_EN
  assign acc_sub = ~k_q[0];
`else
  assign acc_sub = 1'b0;
`endif

  // Accumulate in one extra bit and clamp to the 18-bit signed range so a
  // long run of large terms cannot wrap and defeat the output saturation.
  assign acc_ext  = {acc_q[ACC_W-1], acc_q};
  assign term_ext = {{(ACC_W+1-TERM_W){1'b0}}, mul_p};
  assign acc_sum  = acc_sub ? (acc_ext - term_ext) : (acc_ext + term_ext);

  always_comb begin
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      x2_q     <= '0;
      term_q   <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      x2_q     <= x2_d;
      term_q   <= term_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    x2_d     = x2_q;
    term_d   = term_q;
    p_d      = p_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SQUARE;
          x_d     = x_in;
          term_d  = ONE_Q15;
          acc_d   = ACC_ONE;
          k_d     = '0;
        end
      end
      SQUARE: begin
        // (x*x)>>8 never exceeds 0xFE, so the low byte holds it exactly.
        x2_d    = mul_p[X_W-1:0];
        state_d = STEP_A;
      end
      STEP_A: begin
        p_d     = mul_p;
        state_d = STEP_B;
      end
      STEP_B: begin
        term_d = mul_p;
        acc_d  = acc_next;
        if (k_q == K_LAST) begin
          state_d = FINISH;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = STEP_A;
        end
      end
      FINISH: begin
        result_d = sat_result(acc_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign lut_adr = (state_q == STEP_A || state_q == STEP_B) ? k_q : 3'd0;

endmodule

// File: tb/tb_series_ctrl.sv
// -----------------------------------------------------------------------------
// tb_series_ctrl
// Two instances (TERMS=8 and TERMS=1) share start/x_in/rst_n and one
// coefficient ROM array. A reference model computes each evaluation's
// expected result with plain integer arithmetic at accept time and tracks the
// edge count since accept; every falling edge all outputs of both instances
// are compared against it. Directed cases pin literal values.
// -----------------------------------------------------------------------------
module tb_series_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x_in  = 8'h00;

  logic [2:0]  adr8, adr1;
  logic [7:0]  dat8, dat1;
  logic        busy8, busy1, done8, done1;
  logic [15:0] res8, res1;

  logic [7:0]  rom [8];

  assign dat8 = rom[adr8];
  assign dat1 = rom[adr1];

  always #5 clk = ~clk;

  series_ctrl #(.TERMS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .lut_adr(adr8), .lut_data(dat8), .busy(busy8), .done(done8), .result(res8)
  );

  series_ctrl #(.TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .lut_adr(adr1), .lut_data(dat1), .busy(busy1), .done(done1), .result(res1)
  );

`ifdef SERIES_ALT_SIGN_EN
  localparam logic [15:0] EXP_X80    = 16'h7054;
  localparam logic [15:0] EXP_X80_T1 = 16'h7000;
`else
  localparam logic [15:0] EXP_X80    = 16'h9054;
  localparam logic [15:0] EXP_X80_T1 = 16'h9000;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_terms [2] = '{8, 1};
  bit          m_busy  [2];
  bit          m_done  [2];
  int          m_cnt   [2];
  logic [15:0] m_res   [2];
  logic [15:0] m_pend  [2];

  function automatic logic [15:0] series_ref(input int x, input int t);
    int x2, term, p, acc;
    x2   = (x * x) >> 8;
    term = 32768;
    acc  = 32768;
    for (int k = 0; k < t; k++) begin
      p    = ((term * x2) >> 8) & 16'hFFFF;
      term = ((p * int'(rom[k])) >> 8) & 16'hFFFF;
`ifdef SERIES_ALT_SIGN_EN
      if (k % 2 == 1) acc = acc + term;
      else            acc = acc - term;
`else
      acc = acc + term;
`endif
    end
    if (acc > 65535) return 16'hFFFF;
    if (acc < 0)     return 16'h0000;
    return acc[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_cnt[i]  = 0;
        m_res[i]  = 16'h0000;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == 2 * m_terms[i] + 2) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_res[i]  = m_pend[i];
          end
        end else if (start) begin
          m_busy[i] = 1'b1;
          m_cnt[i]  = 0;
          m_pend[i] = series_ref(int'(x_in), m_terms[i]);
        end
      end
    end
  end

  // Coefficient index in use, derived from edges since accept: after the
  // squaring edge each term occupies two cycles.
  function automatic int exp_adr(input int i);
    if (m_busy[i] && m_cnt[i] >= 1 && m_cnt[i] <= 2 * m_terms[i])
      return (m_cnt[i] - 1) / 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    check("busy8",   32'(busy8), 32'(m_busy[0]));
    check("done8",   32'(done8), 32'(m_done[0]));
    check("result8", 32'(res8),  32'(m_res[0]));
    check("adr8",    32'(adr8),  32'(exp_adr(0)));
    check("busy1",   32'(busy1), 32'(m_busy[1]));
    check("done1",   32'(done1), 32'(m_done[1]));
    check("result1", 32'(res1),  32'(m_res[1]));
    check("adr1",    32'(adr1),  32'(exp_adr(1)));
  end

  // ---------------- directed helpers ----------------
  task automatic load_std_rom();
    rom[0] = 8'h80; rom[1] = 8'h15; rom[2] = 8'h08; rom[3] = 8'h04;
    rom[4] = 8'h02; rom[5] = 8'h01; rom[6] = 8'h01; rom[7] = 8'h01;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy8 || busy1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy8 || busy1), 32'd0);
  endtask

  int adr_trace [64];

  // Start an evaluation, observe done on the selected instance; lat counts
  // rising edges after the accept edge. Optional re-pulses at edges 3 and 10.
  task automatic run_eval(input int sel, input logic [7:0] x, input bit repulse,
                          output logic [15:0] res, output int lat);
    bit got;
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    got = 1'b0;
    res = 16'h0000;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      adr_trace[lat] = (sel == 0) ? int'(adr8) : int'(adr1);
      if ((sel == 0 && done8) || (sel == 1 && done1)) begin
        got = 1'b1;
        res = (sel == 0) ? res8 : res1;
      end
      if (repulse && (lat == 2 || lat == 9)) start = 1'b1;
      if (repulse && (lat == 3 || lat == 10)) start = 1'b0;
    end
    start = 1'b0;
  endtask

  logic [15:0] r;
  int          lat;
  int          done_seen;

  initial begin
    for (int k = 0; k < 8; k++) rom[k] = 8'h00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy",   32'(busy8), 32'd0);
    check("rst_done",   32'(done8), 32'd0);
    check("rst_result", 32'(res8),  32'h0000);
    check("rst_adr",    32'(adr8),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    load_std_rom();

    run_eval(0, 8'h00, 1'b0, r, lat);
    check("x00_result", 32'(r), 32'h8000);
    check("x00_latency", 32'(lat), 32'd18);

    run_eval(0, 8'h80, 1'b0, r, lat);
    check("x80_result", 32'(r), 32'(EXP_X80));
    check("x80_latency", 32'(lat), 32'd18);
    for (int k = 0; k < 8; k++) begin
      check("x80_adr_stepA", 32'(adr_trace[2*k+1]), 32'(k));
      check("x80_adr_stepB", 32'(adr_trace[2*k+2]), 32'(k));
    end
    check("x80_adr_finish", 32'(adr_trace[17]), 32'd0);

    run_eval(1, 8'h80, 1'b0, r, lat);
    check("t1_result", 32'(r), 32'(EXP_X80_T1));
    check("t1_latency", 32'(lat), 32'd4);

    // Re-pulse start during evaluation: ignored, single done.
    run_eval(0, 8'h80, 1'b1, r, lat);
    check("repulse_result", 32'(r), 32'(EXP_X80));
    check("repulse_latency", 32'(lat), 32'd18);
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("repulse_extra_done", 32'(done_seen), 32'd0);

    // Reset at edge 7 of an evaluation.
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    x_in  = 8'h80;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(busy8), 32'd0);
    check("abort_done",   32'(done8), 32'd0);
    check("abort_result", 32'(res8),  32'h0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_eval(0, 8'h80, 1'b0, r, lat);
    check("after_abort_result", 32'(r), 32'(EXP_X80));
    check("after_abort_latency", 32'(lat), 32'd18);

    // Randomized traffic; ROM is only rewritten while nothing is evaluating.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!m_busy[0] && !m_busy[1] && $urandom_range(0, 7) == 0) begin
        bit hi;
        hi = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < 8; k++)
          rom[k] = hi ? 8'(8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 255));
      end
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) x_in = 8'(8'hF0 | 8'($urandom_range(0, 15)));
      else                           x_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/series_ctrl.md
SERIES_CTRL -- requirements
Module: series_ctrl

Interface
REQ-001 SHALL have parameter TERMS, default 8, meaning the number of series terms evaluated (legal range 1..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to evaluate the series; sampled only in IDLE.
REQ-005 SHALL have port x_in  input  8  operand x, unsigned Q0.8; captured on accepted start.
REQ-006 SHALL have port lut_adr  output  3  coefficient address to the external combinational coefficient ROM.
REQ-007 SHALL have port lut_data  input  8  coefficient returned for lut_adr, unsigned Q0.8.
REQ-008 SHALL have port busy  output  1  high from the start-accept edge until done is asserted.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port result  output  16  series sum, unsigned Q1.15; held until the next done.

Function
REQ-011 SHALL implement FSM states IDLE, SQUARE, STEP_A, STEP_B and FINISH.
REQ-012 IDLE SHALL go to SQUARE on start=1, capturing x_in, setting term=0x8000 (1.0), acc=0x8000 and k=0.
REQ-013 SQUARE SHALL compute x2=(x*x)>>8 (8 bits, truncated) and go to STEP_A.
REQ-014 STEP_A SHALL drive lut_adr=k and compute p=(term*x2)>>8 (16 bits, truncated), then go to STEP_B.
REQ-015 STEP_B SHALL hold lut_adr=k and compute term=(p*lut_data)>>8 (16 bits, truncated), then update acc with term.
REQ-016 STEP_B SHALL go to FINISH when k==TERMS-1, and otherwise increment k and go to STEP_A.
REQ-017 FINISH SHALL load result from acc, pulse done for exactly one cycle, drop busy and return to IDLE.
REQ-018 done SHALL assert exactly 2*TERMS+2 clock edges after the start-accept edge; this is 18 edges for TERMS=8.
REQ-019 start while busy SHALL be ignored, with no queuing; start in the FINISH cycle SHALL also be ignored.
REQ-020 acc SHALL be 18-bit signed internally.
REQ-021 result SHALL saturate to 0xFFFF if acc>0xFFFF and clamp to 0x0000 if acc<0.
REQ-022 lut_adr SHALL be 0 outside STEP_A and STEP_B.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, result=0x0000 and lut_adr=0, and clear all internal registers.
REQ-024 reset asserted mid-evaluation SHALL abort it without a done pulse; the first start after release SHALL begin a fresh evaluation.

Configuration
REQ-025 macro SERIES_ALT_SIGN_EN defined: acc SHALL add term when k is odd and subtract it when k is even, giving 1 - t1 + t2 - ...
REQ-026 macro SERIES_ALT_SIGN_EN undefined: acc SHALL add every term, giving 1 + t1 + t2 + ...

Structure
REQ-027 package series_pkg SHALL hold the state enum, the widths X_W=8, TERM_W=16 and ACC_W=18, and the constant ONE_Q15=16'h8000.
REQ-028 the coefficient ROM SHALL remain external, connected through lut_adr/lut_data.
REQ-029 one sub-module, series_mul (truncating 16x8 multiply with >>8), SHALL be instantiated and shared by STEP_A and STEP_B.

Verification
REQ-030 x_in=0x00, TERMS=8, either configuration -> result=0x8000, done 18 edges after start.
REQ-031 x_in=0x80, SERIES_ALT_SIGN_EN defined, standard coefficients (0x80,0x15,0x08,0x04,0x02,0x01,0x01,0x01) -> lut_adr steps 0..7, result=0x7054.
REQ-032 x_in=0x80, SERIES_ALT_SIGN_EN undefined, same coefficients -> result=0x9054.
REQ-033 TERMS=1, x_in=0x80, SERIES_ALT_SIGN_EN defined -> result=0x7000, done 4 edges after start.
REQ-034 start re-pulsed at edges 3 and 10 during evaluation -> single done, result unchanged from REQ-031.
REQ-035 rst_n=0 at edge 7 of an evaluation -> busy=0, done never pulses, result=0x0000; a later start with x_in=0x80 -> 0x7054.
